uart_reg_loader: RTL and testbench

Loads register-file contents from a UART byte stream before program execution. Parses 5-byte records (header plus big-endian 32-bit word) and drives the register file's UART write port: `UART_write_enable`, `rw`, `write_data`, `AorF_before` and the `distinct` toggle token. Sits between the UART receive byte interface and the register file, alongside the core's `RegWrite` path.

---
 rtl/uart_reg_loader.sv | 173 +++++++++++++++++
 tb/tb_uart_reg_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_loader.sv
// UART record loader: parses header + big-endian 32-bit word records and drives the register file's UART write port.
// Optional per-record XOR checksum byte and sticky err flag when LOADER_CHECKSUM_EN is defined.
module uart_reg_loader (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        UART_write_enable,
    output logic        distinct,
    output logic        AorF_before,
    output logic [4:0]  rw,
    output logic [31:0] write_data,
    output logic        busy,
    output logic        done,
    output logic [5:0]  records_written,
    output logic        err
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned BCNT_W  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_WRITE
    } state_t;

    state_t              state, state_d;
    logic [BCNT_W-1:0]   byte_cnt, byte_cnt_d;
    logic [IDX_W-1:0]    rw_d;
    logic                aorf_d;
    logic [DATA_W-1:0]   data_d;
    logic                busy_d, done_d, distinct_d, we_d, ready_d;
    logic [CNT_W-1:0]    cnt_d;
    logic                accept;

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   csum, csum_d;
    logic                err_d;
`endif

    assign accept = rx_valid && rx_ready;

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (reset) begin
            state             <= S_IDLE;
            byte_cnt          <= '0;
            rx_ready          <= 1'b0;
            UART_write_enable <= 1'b0;
            distinct          <= 1'b1;
            AorF_before       <= 1'b0;
            rw                <= '0;
            write_data        <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            records_written   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum              <= '0;
            err               <= 1'b0;
`endif
        end else begin
            state             <= state_d;
            byte_cnt          <= byte_cnt_d;
            rx_ready          <= ready_d;
            UART_write_enable <= we_d;
            distinct          <= distinct_d;
            AorF_before       <= aorf_d;
            rw                <= rw_d;
            write_data        <= data_d;
            busy              <= busy_d;
            done              <= done_d;
            records_written   <= cnt_d;
`ifdef LOADER_CHECKSUM_EN
            csum              <= csum_d;
            err               <= err_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state;
        byte_cnt_d = byte_cnt;
        rw_d       = rw;
        aorf_d     = AorF_before;
        data_d     = write_data;
        busy_d     = busy;
        done_d     = 1'b0;
        cnt_d      = records_written;
        distinct_d = distinct;
        we_d       = 1'b0;
        ready_d    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum;
        err_d      = err;
`endif

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HDR;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_HDR: begin
                if (accept) begin
                    if (rx_data[7]) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = S_DATA;
                        rw_d       = rx_data[4:0];
                        aorf_d     = rx_data[5];
                        byte_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                        csum_d     = rx_data;
`endif
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    data_d     = {write_data[DATA_W-BYTE_W-1:0], rx_data};
                    byte_cnt_d = BCNT_W'(byte_cnt + BCNT_W'(1));
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum ^ rx_data;
                    if (byte_cnt == BCNT_W'(3)) state_d = S_CSUM;
`else
                    if (byte_cnt == BCNT_W'(3)) state_d = S_WRITE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    if (rx_data == csum) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_HDR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            S_WRITE: state_d = S_HDR;
            default: state_d = S_IDLE;
        endcase

        // Write is issued on the edge that enters WRITE; WRITE never self-loops
        if (state_d == S_WRITE) begin
            we_d       = 1'b1;
            distinct_d = ~distinct;
            if (records_written != {CNT_W{1'b1}}) cnt_d = CNT_W'(records_written + CNT_W'(1));
        end

        ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
    end

`ifndef LOADER_CHECKSUM_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_reg_loader.sv
// Directed bench for uart_reg_loader with a register-file model honouring the distinct-token write contract.
module tb_uart_reg_loader;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        UART_write_enable;
    logic        distinct;
    logic        AorF_before;
    logic [4:0]  rw;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic [5:0]  records_written;
    logic        err;

    int total = 0;
    int bad = 0;
    int wr_count = 0;
    int stale_count = 0;
    logic exp_distinct = 1'b1;

    logic        token;
    logic [31:0] rf_int [32];
    logic [31:0] rf_flt [32];

    uart_reg_loader dut (
        .CLK(CLK), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .UART_write_enable(UART_write_enable), .distinct(distinct),
        .AorF_before(AorF_before), .rw(rw), .write_data(write_data), .busy(busy),
        .done(done), .records_written(records_written), .err(err)
    );

    always #5 CLK = ~CLK;

    // Register file model: commits only when enabled and the token differs
    always @(posedge CLK) begin
        if (reset) begin
            token <= 1'b1;
            for (int i = 0; i < 32; i++) begin
                rf_int[i] <= '0;
                rf_flt[i] <= '0;
            end
        end else if (UART_write_enable) begin
            wr_count <= wr_count + 1;
            if (distinct != token) begin
                token <= distinct;
                if (AorF_before) rf_flt[rw] <= write_data;
                else             rf_int[rw] <= write_data;
            end else begin
                stale_count <= stale_count + 1;
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        start = 1'b1;
        rx_valid = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        start = 1'b0;
        exp_distinct = 1'b1;
        tick;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data = b;
        while (!rx_ready && n < 50) begin
            tick;
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $error("FAIL rx_ready_timeout observed=0 expected=1");
        end
        tick;
        rx_valid = 1'b0;
    endtask

    // Header + word (+ checksum when enabled); returns one sample after the final accept
    task automatic send_record(input logic [7:0] hdr, input logic [31:0] w, input logic [7:0] csum_xor);
        send_byte(hdr);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
`ifdef LOADER_CHECKSUM_EN
        send_byte(hdr ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0] ^ csum_xor);
`endif
    endtask

    initial begin
        int w0;
        logic [7:0] seq[$];
        logic [7:0] last;

        // Reset (with start held high: reset wins), then idle
        do_reset;
        repeat (10) tick;
        check("rst_distinct", 32'(distinct), 32'd1);
        check("rst_we", 32'(UART_write_enable), 32'd0);
        check("rst_ready", 32'(rx_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(records_written), 32'd0);
        check("rst_rw", 32'(rw), 32'd0);
        check("rst_data", write_data, 32'h0);
        check("rst_aorf", 32'(AorF_before), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Single record 0x03 / 0xDEADBEEF, latency and hold checks
        pulse_start;
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ready", 32'(rx_ready), 32'd1);
        send_byte(8'h03);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hEF);
        last = 8'h03 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF;
`else
        last = 8'hEF;
`endif
        check("t1_ready_last", 32'(rx_ready), 32'd1);
        rx_valid = 1'b1;
        rx_data = last;
        tick;
        rx_valid = 1'b0;
        exp_distinct = ~exp_distinct;
        check("t1_we", 32'(UART_write_enable), 32'd1);
        check("t1_distinct", 32'(distinct), 32'(exp_distinct));
        check("t1_rw", 32'(rw), 32'd3);
        check("t1_aorf", 32'(AorF_before), 32'd0);
        check("t1_data", write_data, 32'hDEADBEEF);
        check("t1_count", 32'(records_written), 32'd1);
        check("t1_ready_wr", 32'(rx_ready), 32'd0);
        tick;
        check("t1_we_fall", 32'(UART_write_enable), 32'd0);
        check("t1_ready_back", 32'(rx_ready), 32'd1);
        check("t1_data_hold", write_data, 32'hDEADBEEF);
        send_byte(8'h80);
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy_fall", 32'(busy), 32'd0);
        tick;
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_wr_count", 32'(wr_count), 32'd1);
        check("t1_rf_r3", rf_int[3], 32'hDEADBEEF);

        // Two records after a fresh reset: f[5] and r[0]
        do_reset;
        pulse_start;
        send_record(8'h25, 32'h3F800000, 8'h00);
        check("t2_distinct_a", 32'(distinct), 32'd0);
        check("t2_aorf", 32'(AorF_before), 32'd1);
        send_record(8'h00, 32'h00000001, 8'h00);
        check("t2_distinct_b", 32'(distinct), 32'd1);
        send_byte(8'h80);
        tick;
        check("t2_count", 32'(records_written), 32'd2);
        check("t2_rf_f5", rf_flt[5], 32'h3F800000);
        check("t2_rf_r0", rf_int[0], 32'h00000001);
        exp_distinct = 1'b1;

        // Half-rate rx_valid; h[6] ignored; start while busy ignored
        pulse_start;
        seq.delete();
        seq.push_back(8'h4A);
        seq.push_back(8'h12);
        seq.push_back(8'h34);
        seq.push_back(8'h56);
        seq.push_back(8'h78);
`ifdef LOADER_CHECKSUM_EN
        seq.push_back(8'h4A ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78);
`endif
        w0 = wr_count;
        for (int i = 0; i < seq.size(); i++) begin
            rx_valid = 1'b1;
            rx_data = seq[i];
            tick;
            rx_valid = 1'b0;
            if (i == seq.size() - 1) check("t4_we_latency", 32'(UART_write_enable), 32'd1);
            tick;
        end
        exp_distinct = ~exp_distinct;
        check("t4_distinct", 32'(distinct), 32'(exp_distinct));
        check("t4_rw", 32'(rw), 32'd10);
        pulse_start;
        check("t4_count_keep", 32'(records_written), 32'd1);
        send_byte(8'h80);
        tick;
        check("t4_writes", 32'(wr_count - w0), 32'd1);
        check("t4_rf_r10", rf_int[10], 32'h12345678);

        // Reset mid-record, then fresh session writing r[7]
        pulse_start;
        send_byte(8'h07);
        send_byte(8'hAA);
        send_byte(8'hBB);
        w0 = wr_count;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        exp_distinct = 1'b1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ready", 32'(rx_ready), 32'd0);
        check("t5_distinct", 32'(distinct), 32'd1);
        check("t5_data", write_data, 32'h0);
        check("t5_rw", 32'(rw), 32'd0);
        repeat (5) tick;
        check("t5_no_write", 32'(wr_count - w0), 32'd0);
        pulse_start;
        send_record(8'h07, 32'h11223344, 8'h00);
        send_byte(8'h80);
        tick;
        check("t5_writes", 32'(wr_count - w0), 32'd1);
        check("t5_rf_r7", rf_int[7], 32'h11223344);

        // Counter saturation after 64 records
        do_reset;
        pulse_start;
        for (int i = 0; i < 64; i++) begin
            send_record(8'(i % 32), 32'(i), 8'h00);
            exp_distinct = ~exp_distinct;
            if (i == 62) check("sat_63", 32'(records_written), 32'd63);
        end
        check("sat_hold", 32'(records_written), 32'd63);
        check("sat_distinct", 32'(distinct), 32'(exp_distinct));
        send_byte(8'h80);
        tick;
        check("sat_rf_r31", rf_int[31], 32'd63);

`ifdef LOADER_CHECKSUM_EN
        // Good and bad checksums
        do_reset;
        pulse_start;
        w0 = wr_count;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h04);
        check("cs_good_we", 32'(UART_write_enable), 32'd1);
        check("cs_good_distinct", 32'(distinct), 32'd0);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h00);
        check("cs_bad_we", 32'(UART_write_enable), 32'd0);
        check("cs_bad_distinct", 32'(distinct), 32'd0);
        check("cs_bad_err", 32'(err), 32'd1);
        check("cs_bad_count", 32'(records_written), 32'd1);
        send_byte(8'h80);
        tick;
        check("cs_err_sticky", 32'(err), 32'd1);
        check("cs_writes", 32'(wr_count - w0), 32'd1);
        check("cs_rf_r1", rf_int[1], 32'h00000005);
        pulse_start;
        check("cs_err_start", 32'(err), 32'd1);
        do_reset;
        check("cs_err_clear", 32'(err), 32'd0);
`endif

        check("stale_writes", 32'(stale_count), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
